// File: rtl/btn_event_gen.sv
// Push-button front end: 2-flop synchronizers, per-button debounce, rising-edge
// press pulses and a single-entry press event latch behind a valid/ack handshake.
module btn_event_gen #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_raw,
  input  logic       ack,
  output logic [3:0] btn_level,
  output logic [3:0] press_pulse,
  output logic       evt_valid,
  output logic [1:0] evt_code,
  output logic       evt_multi,
  output logic       overflow
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  state_t           state_r;
  logic [3:0]       sync1_r;
  logic [3:0]       sync2_r;
  logic [3:0]       level_prev_r;
  logic [CNT_W-1:0] cnt_r [4];

  // D has the highest priority, L the lowest.
  function automatic logic [1:0] lowest_idx(input logic [3:0] p);
    logic [1:0] idx;
    casez (p)
      4'b???1: idx = 2'd0;
      4'b??10: idx = 2'd1;
      4'b?100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  function automatic logic is_multi(input logic [3:0] p);
    return (p & (p - 4'd1)) != 4'd0;
  endfunction

  // Two-stage synchronizer for the asynchronous button inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 4'b0000;
      sync2_r <= 4'b0000;
    end else begin
      sync1_r <= btn_raw;
      sync2_r <= sync1_r;
    end
  end

  // Per-button debounce: a level change is accepted after DEBOUNCE_CYCLES
  // consecutive disagreeing samples; any agreeing sample restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_level <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        cnt_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync2_r[i] == btn_level[i]) begin
          cnt_r[i] <= '0;
        end else if (cnt_r[i] == CNT_LAST) begin
          btn_level[i] <= sync2_r[i];
          cnt_r[i]     <= '0;
        end else begin
          cnt_r[i] <= cnt_r[i] + CNT_ONE;
        end
      end
    end
  end

  // One-cycle pulse in the cycle after a debounced 0->1 transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_prev_r <= 4'b0000;
      press_pulse  <= 4'b0000;
    end else begin
      level_prev_r <= btn_level;
      press_pulse  <= btn_level & ~level_prev_r;
    end
  end

  // Event latch; a new press in the ack cycle replaces the event rather than being lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      evt_valid <= 1'b0;
      evt_code  <= 2'd0;
      evt_multi <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (press_pulse != 4'b0000) begin
            state_r   <= PENDING;
            evt_valid <= 1'b1;
            evt_code  <= lowest_idx(press_pulse);
            evt_multi <= is_multi(press_pulse);
          end else begin
            evt_valid <= 1'b0;
          end
        end
        PENDING: begin
          if (press_pulse != 4'b0000) begin
            if (ack) begin
              evt_code  <= lowest_idx(press_pulse);
              evt_multi <= is_multi(press_pulse);
            end else begin
              overflow <= 1'b1;
            end
          end else if (ack) begin
            state_r   <= IDLE;
            evt_valid <= 1'b0;
          end else begin
            evt_valid <= 1'b1;
          end
        end
        default: begin
          state_r   <= IDLE;
          evt_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btn_event_gen.sv
// Directed test-plan steps followed by a random phase, all checked against a
// sliding-window behavioural model of debounce, pulse and event handshake.
module tb_btn_event_gen;

  localparam int D = 4;

  logic       clk;
  logic       rst;
  logic [3:0] btn_raw;
  logic       ack;
  logic [3:0] btn_level;
  logic [3:0] press_pulse;
  logic       evt_valid;
  logic [1:0] evt_code;
  logic       evt_multi;
  logic       overflow;

  int errors = 0;
  int checks = 0;

  btn_event_gen #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .ack(ack),
    .btn_level(btn_level), .press_pulse(press_pulse), .evt_valid(evt_valid),
    .evt_code(evt_code), .evt_multi(evt_multi), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [3:0] m_s1, m_s2, m_lvl, m_lvl_prev, m_pp;
  logic [3:0] hist[$];
  logic       m_valid, m_multi, m_ovf;
  logic [1:0] m_code;

  function automatic void model_reset();
    m_s1 = 4'b0; m_s2 = 4'b0; m_lvl = 4'b0; m_lvl_prev = 4'b0; m_pp = 4'b0;
    hist.delete();
    m_valid = 1'b0; m_multi = 1'b0; m_ovf = 1'b0; m_code = 2'd0;
  endfunction

  function automatic logic [1:0] first_set(input logic [3:0] p);
    for (int i = 0; i < 4; i++) if (p[i]) return 2'(i);
    return 2'd0;
  endfunction

  // A level flips once the last D synchronized samples all disagree with it.
  function automatic void model_step(input logic [3:0] r, input logic a);
    logic [3:0] new_lvl;
    logic [3:0] p;
    logic       all_diff;
    p = m_pp;
    hist.push_back(m_s2);
    if (hist.size() > D) void'(hist.pop_front());
    new_lvl = m_lvl;
    if (hist.size() == D) begin
      for (int i = 0; i < 4; i++) begin
        all_diff = 1'b1;
        foreach (hist[k]) if (hist[k][i] == m_lvl[i]) all_diff = 1'b0;
        if (all_diff) new_lvl[i] = ~m_lvl[i];
      end
    end
    m_pp       = m_lvl & ~m_lvl_prev;
    m_lvl_prev = m_lvl;
    m_lvl      = new_lvl;
    m_s2       = m_s1;
    m_s1       = r;
    if (!m_valid) begin
      if (p != 4'b0) begin
        m_valid = 1'b1; m_code = first_set(p); m_multi = ($countones(p) >= 2);
      end
    end else if (p != 4'b0) begin
      if (a) begin
        m_code = first_set(p); m_multi = ($countones(p) >= 2);
      end else begin
        m_ovf = 1'b1;
      end
    end else if (a) begin
      m_valid = 1'b0;
    end
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("level",    int'(btn_level),   int'(m_lvl));
    chk("pulse",    int'(press_pulse), int'(m_pp));
    chk("valid",    int'(evt_valid),   int'(m_valid));
    chk("code",     int'(evt_code),    int'(m_code));
    chk("multi",    int'(evt_multi),   int'(m_multi));
    chk("overflow", int'(overflow),    int'(m_ovf));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_step(btn_raw, ack);
    @(negedge clk);
    check_all();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_level"}, int'(btn_level), 0);
    chk({tag, "_pulse"}, int'(press_pulse), 0);
    chk({tag, "_valid"}, int'(evt_valid), 0);
    chk({tag, "_code"},  int'(evt_code), 0);
    chk({tag, "_multi"}, int'(evt_multi), 0);
    chk({tag, "_ovf"},   int'(overflow), 0);
  endtask

  initial begin
    int         pulses;
    logic       found;
    logic [7:0] bounce;
    int         bit_sel;

    btn_raw = 4'b0; ack = 1'b0; rst = 1'b1;
    model_reset();
    repeat (2) tick();
    check_zero("reset");
    rst = 1'b0;

    // 1. Clean press of D
    btn_raw = 4'b0001;
    repeat (5) tick();
    chk("t1_level_edge5", int'(btn_level), 0);
    tick();
    chk("t1_level_edge6", int'(btn_level), 1);
    tick();
    chk("t1_pulse_edge7", int'(press_pulse), 1);
    tick();
    chk("t1_valid_edge8", int'(evt_valid), 1);
    chk("t1_code", int'(evt_code), 0);
    chk("t1_multi", int'(evt_multi), 0);
    pulses = 0;
    repeat (12) begin tick(); pulses += int'($countones(press_pulse)); end
    chk("t1_extra_pulses", pulses, 0);
    chk("t1_still_valid", int'(evt_valid), 1);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("t1_acked", int'(evt_valid), 0);

    // 2. Bouncy U press
    bounce = 8'b0111_0111;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      btn_raw = {1'b0, bounce[k], 1'b0, 1'b1};
      tick();
      pulses += int'(press_pulse[2]);
      chk("t2_level_during_bounce", int'(btn_level[2]), 0);
    end
    btn_raw = 4'b0101;
    repeat (12) begin tick(); pulses += int'(press_pulse[2]); end
    chk("t2_level_after", int'(btn_level[2]), 1);
    chk("t2_one_pulse", pulses, 1);
    chk("t2_code", int'(evt_code), 2);
    ack = 1'b1; tick(); ack = 1'b0;
    btn_raw = 4'b0000;
    repeat (10) tick();
    chk("t2_released", int'(btn_level), 0);

    // 3. Simultaneous R and L
    btn_raw = 4'b1010;
    repeat (7) tick();
    chk("t3_pulse", int'(press_pulse), 4'b1010);
    tick();
    chk("t3_code", int'(evt_code), 1);
    chk("t3_multi", int'(evt_multi), 1);

    // 4. Overflow while pending, then ack
    btn_raw = 4'b0000;
    repeat (10) tick();
    chk("t4_no_ovf_yet", int'(overflow), 0);
    btn_raw = 4'b1000;
    repeat (8) tick();
    chk("t4_ovf", int'(overflow), 1);
    chk("t4_code_kept", int'(evt_code), 1);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("t4_valid_cleared", int'(evt_valid), 0);
    chk("t4_ovf_sticky", int'(overflow), 1);

    // 5. Ack in the same cycle as a new U pulse
    btn_raw = 4'b1001;
    repeat (8) tick();
    chk("t5_pending_d", int'(evt_code), 0);
    btn_raw = 4'b1101;
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      tick();
      found = m_pp[2];
    end
    chk("t5_u_pulse_seen", int'(found), 1);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("t5_valid_kept", int'(evt_valid), 1);
    chk("t5_code_u", int'(evt_code), 2);
    chk("t5_ovf_unchanged", int'(overflow), 1);

    // 6. Reset with an event pending and R debounce count at 3
    btn_raw = 4'b0000;
    repeat (10) tick();
    btn_raw = 4'b0010;
    repeat (5) tick();
    rst = 1'b1;
    model_reset();
    #1;
    check_zero("t6_async");
    tick();
    rst = 1'b0;
    repeat (5) tick();
    chk("t6_level_edge5", int'(btn_level), 0);
    tick();
    chk("t6_level_edge6", int'(btn_level), 2);
    tick();
    chk("t6_pulse", int'(press_pulse), 2);
    tick();
    chk("t6_valid", int'(evt_valid), 1);
    chk("t6_code", int'(evt_code), 1);

    // Random phase
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        bit_sel = int'($urandom_range(0, 3));
        btn_raw[bit_sel] = ~btn_raw[bit_sel];
      end
      ack = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1;
        model_reset();
        #1;
        check_zero("rand_rst");
        tick();
        rst = 1'b0;
      end else begin
        tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
